// File: rtl/draw_source_sequencer_pkg.sv
// Shared draw package: frame manager constants, pixel bus widths, and the
// draw source sequencer state encoding.
package draw_source_sequencer_pkg;

  localparam int FRAME_WIDTH       = 640;
  localparam int FRAME_HEIGHT      = 480;
  localparam int DRAW_WIDTH_ADDRW  = $clog2(FRAME_WIDTH);
  localparam int DRAW_HEIGHT_ADDRW = $clog2(FRAME_HEIGHT);
  localparam int COLOR_DEPTH       = 8;
  localparam int SOURCE_SEL_ADDRW  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_AWAIT,
    S_DRAWING,
    S_NEXT,
    S_DONE
  } draw_state_e;

  typedef struct packed {
    logic [DRAW_WIDTH_ADDRW-1:0]  x;
    logic [DRAW_HEIGHT_ADDRW-1:0] y;
    logic [COLOR_DEPTH-1:0]       data;
  } pixel_t;

endpackage

// File: rtl/draw_source_sequencer_watchdog.sv
// draw_watchdog: counts cycles while start is high; expired fires on the
// TIMEOUT_CYCLES-th counted cycle. clear restarts the count.
module draw_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic resetN,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = start && (cnt == LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                 cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (start && !expired)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/draw_source_sequencer.sv
// Grants the shared pixel write bus to each draw source in turn and forwards
// opaque pixels to the framebuffer. DRAW_SEQ_TIMEOUT_EN adds a per-source wait limit.
module draw_source_sequencer
  import draw_source_sequencer_pkg::*;
#(
  parameter int SOURCE_COUNT   = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         frame_start,
  output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
  output logic                         write_awaited,
  input  logic                         write_active,
  input  logic                         write_transparent,
  input  logic [COLOR_DEPTH-1:0]       write_color_data,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
  output logic                         fb_we,
  output logic [DRAW_WIDTH_ADDRW-1:0]  fb_x,
  output logic [DRAW_HEIGHT_ADDRW-1:0] fb_y,
  output logic [COLOR_DEPTH-1:0]       fb_data,
  output logic                         frame_done,
  output logic                         frame_overrun,
  output logic                         timeout_flag
);

  localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_IDX = SOURCE_SEL_ADDRW'(SOURCE_COUNT - 1);

  draw_state_e                 state, state_nxt;
  logic [SOURCE_SEL_ADDRW-1:0] idx, idx_nxt;
  logic                        act, capture, expired;
  pixel_t                      pix_in, pix_q;

  // Floating or unknown bus reads as idle.
  assign act    = (write_active === 1'b1);
  assign pix_in = '{x: write_x_addr, y: write_y_addr, data: write_color_data};

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE:    if (frame_start) begin
                   state_nxt = S_SELECT;
                   idx_nxt   = '0;
                 end
      S_SELECT:  state_nxt = S_AWAIT;
      S_AWAIT:   if (act)          state_nxt = S_DRAWING;
                 else if (expired) state_nxt = S_NEXT;
      S_DRAWING: if (!act)         state_nxt = S_NEXT;
      S_NEXT:    if (idx == LAST_IDX) state_nxt = S_DONE;
                 else begin
                   idx_nxt   = idx + 1'b1;
                   state_nxt = S_SELECT;
                 end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign write_awaited    = (state == S_AWAIT) || (state == S_DRAWING);
  assign write_source_sel = (state == S_SELECT || state == S_AWAIT ||
                             state == S_DRAWING || state == S_NEXT) ? idx : '0;
  assign frame_done       = (state == S_DONE);
  assign capture          = write_awaited && act && !write_transparent;
  assign fb_x             = pix_q.x;
  assign fb_y             = pix_q.y;
  assign fb_data          = pix_q.data;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= S_IDLE;
      idx           <= '0;
      fb_we         <= 1'b0;
      pix_q         <= '0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      fb_we         <= capture;
      frame_overrun <= frame_start && (state != S_IDLE);
      if (capture) pix_q <= pix_in;
    end
  end

`ifdef DRAW_SEQ_TIMEOUT_EN
  // Count restarts in SELECT so every source gets a full AWAIT window.
  draw_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .resetN  (resetN),
    .start   (state == S_AWAIT),
    .clear   (state == S_SELECT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                                  timeout_flag <= 1'b0;
    else if (state == S_AWAIT && !act && expired) timeout_flag <= 1'b1;
  end
`else
  assign expired      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_draw_source_sequencer.sv
// Directed bench for draw_source_sequencer: full frames, transparency,
// overruns, mid-frame reset, and (with DRAW_SEQ_TIMEOUT_EN) the source timeout.
module tb_draw_source_sequencer;
  import draw_source_sequencer_pkg::*;

  localparam int NSRC = 3;
`ifdef DRAW_SEQ_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif
  localparam int SW = SOURCE_SEL_ADDRW;

  logic                         clk = 1'b0;
  logic                         resetN = 1'b0;
  logic                         frame_start = 1'b0;
  logic                         write_active = 1'b0;
  logic                         write_transparent = 1'b0;
  logic [COLOR_DEPTH-1:0]       write_color_data = '0;
  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr = '0;
  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr = '0;
  logic [SW-1:0]                write_source_sel;
  logic                         write_awaited, fb_we, frame_done, frame_overrun, timeout_flag;
  logic [DRAW_WIDTH_ADDRW-1:0]  fb_x;
  logic [DRAW_HEIGHT_ADDRW-1:0] fb_y;
  logic [COLOR_DEPTH-1:0]       fb_data;

  int n_cmp = 0;
  int n_err = 0;
  int done_pulses = 0;

  draw_source_sequencer #(.SOURCE_COUNT(NSRC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start),
    .write_source_sel(write_source_sel), .write_awaited(write_awaited),
    .write_active(write_active), .write_transparent(write_transparent),
    .write_color_data(write_color_data), .write_x_addr(write_x_addr),
    .write_y_addr(write_y_addr), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .fb_data(fb_data), .frame_done(frame_done), .frame_overrun(frame_overrun),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_pulses++;

  function automatic pixel_t exp_pix(input int id, input int k);
    exp_pix = '{x: DRAW_WIDTH_ADDRW'(id * 100 + k), y: DRAW_HEIGHT_ADDRW'(k * 3 + id),
                data: COLOR_DEPTH'(k ^ (id << 5))};
  endfunction

  task automatic drive_pix(input logic act, input logic tr, input int id, input int k);
    pixel_t p;
    p = exp_pix(id, k);
    write_active = act; write_transparent = tr;
    write_x_addr = p.x; write_y_addr = p.y; write_color_data = p.data;
  endtask

  // Entered on the negedge of this source's SELECT cycle; leaves on the
  // negedge following its NEXT cycle.
  task automatic serve(input int id, input int n, input int tr_mod, input int zcyc,
                       input int ovr_k, output int we_cnt);
    logic   prev_we, tr, exp_ovr;
    pixel_t got, want;
    we_cnt = 0;
    n_cmp++;
    if ({write_source_sel, write_awaited, fb_we} !== {SW'(id), 2'b00}) begin
      n_err++;
      $display("FAIL select src%0d: got sel/aw/we %h want %h", id,
               {write_source_sel, write_awaited, fb_we}, {SW'(id), 2'b00});
    end
    drive_pix(1'b0, 1'b0, id, 0);
    @(negedge clk);
    for (int c = 0; c < zcyc; c++) begin
      n_cmp++;
      if ({write_source_sel, write_awaited, fb_we} !== {SW'(id), 2'b10}) begin
        n_err++;
        $display("FAIL await_z src%0d c%0d: got %h want %h", id, c,
                 {write_source_sel, write_awaited, fb_we}, {SW'(id), 2'b10});
      end
      write_active = 1'bz;
      @(negedge clk);
    end
    prev_we = 1'b0;
    for (int k = 0; k <= n; k++) begin
      n_cmp++;
      if ({write_source_sel, write_awaited, fb_we} !== {SW'(id), 1'b1, prev_we}) begin
        n_err++;
        $display("FAIL pix_we src%0d k%0d: got sel/aw/we %h want %h", id, k,
                 {write_source_sel, write_awaited, fb_we}, {SW'(id), 1'b1, prev_we});
      end
      if (prev_we && fb_we === 1'b1) begin
        got  = '{x: fb_x, y: fb_y, data: fb_data};
        want = exp_pix(id, k - 1);
        we_cnt++;
        n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL pix_data src%0d k%0d: got %h want %h", id, k - 1, got, want);
        end
      end
      exp_ovr = (ovr_k >= 0 && k - 1 == ovr_k);
      n_cmp++;
      if (frame_overrun !== exp_ovr) begin
        n_err++;
        $display("FAIL overrun src%0d k%0d: got %b want %b", id, k, frame_overrun, exp_ovr);
      end
      frame_start = 1'b0;
      if (k < n) begin
        tr = (tr_mod != 0) && (k % tr_mod == 2);
        drive_pix(1'b1, tr, id, k);
        if (k == ovr_k) frame_start = 1'b1;
        prev_we = !tr;
      end else begin
        drive_pix(1'b0, 1'b0, id, k);
        prev_we = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({write_source_sel, write_awaited, fb_we} !== {SW'(id), 2'b00}) begin
      n_err++;
      $display("FAIL next src%0d: got sel/aw/we %h want %h", id,
               {write_source_sel, write_awaited, fb_we}, {SW'(id), 2'b00});
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int n, input int tr_mod1, input int ovr_k0, input bit ovr_done,
                           output int we0, output int we1, output int we2);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    serve(0, n, 0, 0, ovr_k0, we0);
    serve(1, n, tr_mod1, 0, -1, we1);
    serve(2, n, 0, 0, -1, we2);
    n_cmp++;
    if ({frame_done, write_source_sel, write_awaited, fb_we} !== {1'b1, SW'(0), 2'b00}) begin
      n_err++;
      $display("FAIL done: got done/sel/aw/we %h want %h",
               {frame_done, write_source_sel, write_awaited, fb_we}, {1'b1, SW'(0), 2'b00});
    end
    if (ovr_done) frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n_cmp++;
    if ({frame_done, frame_overrun, write_awaited, fb_we} !== {1'b0, ovr_done, 2'b00}) begin
      n_err++;
      $display("FAIL idle_after_done: got done/ovr/aw/we %b want %b",
               {frame_done, frame_overrun, write_awaited, fb_we}, {1'b0, ovr_done, 2'b00});
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({write_source_sel, write_awaited, fb_we, fb_x, fb_y, fb_data, frame_done,
         frame_overrun, timeout_flag} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got sel %h aw %b we %b x %h y %h d %h done %b ovr %b to %b want all 0",
               write_source_sel, write_awaited, fb_we, fb_x, fb_y, fb_data, frame_done,
               frame_overrun, timeout_flag);
    end
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({write_awaited, fb_we, frame_done} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_release: got aw/we/done %b want 000",
               {write_awaited, fb_we, frame_done});
    end
  endtask

  task automatic test_frame;
    int w0, w1, w2, d0;
    d0 = done_pulses;
    run_frame(50, 0, -1, 1'b0, w0, w1, w2);
    n_cmp++;
    if (w0 + w1 + w2 !== 150) begin
      n_err++;
      $display("FAIL frame_we_total: got %0d want 150", w0 + w1 + w2);
    end
    n_cmp++;
    if (done_pulses - d0 !== 1) begin
      n_err++;
      $display("FAIL frame_done_count: got %0d want 1", done_pulses - d0);
    end
  endtask

  task automatic test_transparent;
    int w0, w1, w2;
    run_frame(50, 5, -1, 1'b0, w0, w1, w2);
    n_cmp++;
    if ({w0, w1, w2} !== {32'd50, 32'd40, 32'd50}) begin
      n_err++;
      $display("FAIL transparent_we: got %0d/%0d/%0d want 50/40/50", w0, w1, w2);
    end
  endtask

  task automatic test_overrun;
    int w0, w1, w2, d0;
    d0 = done_pulses;
    run_frame(50, 0, 5, 1'b0, w0, w1, w2);
    n_cmp++;
    if (done_pulses - d0 !== 1 || w0 + w1 + w2 !== 150) begin
      n_err++;
      $display("FAIL overrun_frame: got done %0d we %0d want done 1 we 150",
               done_pulses - d0, w0 + w1 + w2);
    end
  endtask

  task automatic test_overrun_at_done;
    int w0, w1, w2;
    run_frame(4, 0, -1, 1'b1, w0, w1, w2);
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({write_awaited, fb_we, frame_overrun} !== 3'b000) begin
        n_err++;
        $display("FAIL no_pass_after_done_overrun: got aw/we/ovr %b want 000",
                 {write_awaited, fb_we, frame_overrun});
      end
    end
  endtask

  task automatic test_bus_z;
    int w0, w1, w2;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    serve(0, 3, 0, 4, -1, w0);
    serve(1, 3, 0, 0, -1, w1);
    serve(2, 3, 0, 2, -1, w2);
    n_cmp++;
    if (frame_done !== 1'b1 || w0 + w1 + w2 !== 9) begin
      n_err++;
      $display("FAIL bus_z_frame: got done %b we %0d want done 1 we 9", frame_done, w0 + w1 + w2);
    end
    @(negedge clk);
  endtask

`ifdef DRAW_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int w0, w1, c, d0;
    d0 = done_pulses;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    serve(0, 5, 0, 0, -1, w0);
    serve(1, 5, 0, 0, -1, w1);
    n_cmp++;
    if ({write_source_sel, write_awaited, timeout_flag} !== {SW'(2), 2'b00}) begin
      n_err++;
      $display("FAIL timeout_select: got %h want %h",
               {write_source_sel, write_awaited, timeout_flag}, {SW'(2), 2'b00});
    end
    write_active = 1'b0;
    @(negedge clk);
    c = 0;
    while (write_awaited === 1'b1 && c < 100) begin
      c++;
      @(negedge clk);
    end
    n_cmp++;
    if (c !== 20) begin
      n_err++;
      $display("FAIL timeout_await_cycles: got %0d want 20", c);
    end
    n_cmp++;
    if ({write_source_sel, fb_we, timeout_flag} !== {SW'(2), 2'b01}) begin
      n_err++;
      $display("FAIL timeout_next: got sel/we/flag %h want %h",
               {write_source_sel, fb_we, timeout_flag}, {SW'(2), 2'b01});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_pulses - d0 !== 1 || timeout_flag !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_done: got done %0d flag %b want 1 1", done_pulses - d0, timeout_flag);
    end
  endtask
`endif

  task automatic test_reset_mid_draw;
    int w0, w1, w2;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    serve(0, 5, 0, 0, -1, w0);
    drive_pix(1'b0, 1'b0, 1, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive_pix(1'b1, 1'b0, 1, k);
      @(negedge clk);
    end
    n_cmp++;
    if ({write_source_sel, write_awaited, fb_we} !== {SW'(1), 2'b11}) begin
      n_err++;
      $display("FAIL pre_reset_drawing: got %h want %h",
               {write_source_sel, write_awaited, fb_we}, {SW'(1), 2'b11});
    end
    drive_pix(1'b1, 1'b0, 1, 3);
    resetN = 1'b0;
    #1;
    n_cmp++;
    if ({write_source_sel, write_awaited, fb_we, fb_x, fb_y, fb_data, frame_done,
         frame_overrun, timeout_flag} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_draw: got sel %h aw %b we %b x %h y %h d %h done %b ovr %b to %b want all 0",
               write_source_sel, write_awaited, fb_we, fb_x, fb_y, fb_data, frame_done,
               frame_overrun, timeout_flag);
    end
    @(negedge clk);
    resetN = 1'b1;
    for (int k = 4; k < 9; k++) begin
      drive_pix(1'b1, 1'b0, 1, k);
      @(negedge clk);
      n_cmp++;
      if ({write_source_sel, write_awaited, fb_we} !== {SW'(0), 2'b00}) begin
        n_err++;
        $display("FAIL idle_after_reset k%0d: got %h want %h", k,
                 {write_source_sel, write_awaited, fb_we}, {SW'(0), 2'b00});
      end
    end
    drive_pix(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    run_frame(3, 0, -1, 1'b0, w0, w1, w2);
    n_cmp++;
    if (w0 + w1 + w2 !== 9) begin
      n_err++;
      $display("FAIL recover_frame_we: got %0d want 9", w0 + w1 + w2);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got stuck want done");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "bench timeout");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_frame;
    test_transparent;
    test_overrun;
    test_overrun_at_done;
    test_bus_z;
`ifdef DRAW_SEQ_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid_draw;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
